// File: rtl/piso_frame_pkg.sv
// Shared types and sizing helpers for the PISO frame serializer.
// PISO_PARITY_EN adds one parity bit after the data field.
package piso_frame_pkg;

`ifdef PISO_PARITY_EN
    localparam int PAR_W = 1;
`else
    localparam int PAR_W = 0;
`endif

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Total frame length: preamble, start bit, data, optional parity, postamble.
    function automatic int frame_w(input int data_w, input int pre_w, input int post_w);
        return pre_w + 1 + data_w + PAR_W + post_w;
    endfunction

    function automatic int cnt_w(input int fw);
        return $clog2(fw + 1);
    endfunction

    function automatic int div_w(input int clks_per_bit);
        return (clks_per_bit > 1) ? $clog2(clks_per_bit) : 1;
    endfunction

endpackage

// File: rtl/piso_bit_tick.sv
// Bit-period divider: asserts last_cycle in the final clk of each bit and
// bit_tick when that coincides with an active frame.
module piso_bit_tick
    import piso_frame_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_run,
    input  logic i_restart,
    output logic o_bit_tick,
    output logic o_last_cycle
);

    generate
        if (CLKS_PER_BIT == 1) begin : g_const
            // Every cycle is a full bit-period, so no counter exists.
            logic w_unused_ports;
            assign w_unused_ports = &{1'b0, clk, rst_n, i_restart};
            assign o_last_cycle   = 1'b1;
        end else begin : g_div
            localparam int DW = div_w(CLKS_PER_BIT);
            localparam logic [DW-1:0] DIV_MAX = DW'(CLKS_PER_BIT - 1);

            logic [DW-1:0] r_div;

            // NOTE: sequential state uses non-blocking assignments and an async
            // reset so every flop updates from pre-edge values.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_div <= '0;
                end else if (i_restart) begin
                    r_div <= '0;
                end else if (i_run) begin
                    r_div <= (r_div == DIV_MAX) ? '0 : r_div + 1'b1;
                end
            end

            assign o_last_cycle = (r_div == DIV_MAX);
        end
    endgenerate

    assign o_bit_tick = i_run & o_last_cycle;

endmodule

// File: rtl/piso_frame_serializer.sv
// Parallel-in/serial-out frame generator with valid/ready intake and gated output.
// Build option: define PISO_PARITY_EN to append a parity bit after the data.
module piso_frame_serializer
    import piso_frame_pkg::*;
#(
    parameter int         DATA_W       = 5,
    parameter int         PRE_W        = 4,
    parameter logic [7:0] PRE_PAT      = 8'b0000_1111,
    parameter int         POST_W       = 6,
    parameter logic [7:0] POST_PAT     = 8'b0011_1101,
    parameter int         CLKS_PER_BIT = 1,
    parameter logic       IDLE_LVL     = 1'b1,
    parameter logic       PARITY_ODD   = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              out_en,
    output logic              ser_out,
    output logic              busy,
    output logic              frame_done
);

    localparam int FRAME_W = frame_w(DATA_W, PRE_W, POST_W);
    localparam int CNT_W   = cnt_w(FRAME_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_W - 1);

    state_t               r_state;
    logic [FRAME_W-1:0]   r_shift;
    logic [CNT_W-1:0]     r_bit_cnt;
    logic                 r_frame_done;
    logic [FRAME_W-1:0]   w_frame;
    logic                 w_busy;
    logic                 w_accept;
    logic                 w_frame_end;
    logic                 w_bit_tick;
    logic                 w_last_cycle;

    assign w_busy = (r_state == ST_SHIFT);

    piso_bit_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_tick (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_run       (w_busy),
        .i_restart   (w_accept),
        .o_bit_tick  (w_bit_tick),
        .o_last_cycle(w_last_cycle)
    );

    // Opening ready in the final cycle of the last bit gives zero-gap frames.
    assign w_frame_end = w_busy && (r_bit_cnt == LAST_BIT) && w_last_cycle;
    assign in_ready    = !w_busy || w_frame_end;
    assign w_accept    = in_valid && in_ready;

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        w_frame = '0;
        for (int i = 0; i < PRE_W; i++) begin
            w_frame[i] = PRE_PAT[i];
        end
        w_frame[PRE_W] = 1'b0;
        for (int i = 0; i < DATA_W; i++) begin
            w_frame[PRE_W + 1 + i] = in_data[i];
        end
`ifdef PISO_PARITY_EN
        w_frame[PRE_W + 1 + DATA_W] = (^in_data) ^ PARITY_ODD;
`endif
        for (int i = 0; i < POST_W; i++) begin
            w_frame[PRE_W + 1 + DATA_W + PAR_W + i] = POST_PAT[i];
        end
    end

`ifndef PISO_PARITY_EN
    logic w_unused_parity;
    assign w_unused_parity = PARITY_ODD;
`endif

    // Shifting fills with IDLE_LVL, so the register is all-idle once a frame ends.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_shift      <= {FRAME_W{IDLE_LVL}};
            r_bit_cnt    <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_frame_end;
            if (w_accept) begin
                r_state   <= ST_SHIFT;
                r_shift   <= w_frame;
                r_bit_cnt <= '0;
            end else if (w_frame_end) begin
                r_state   <= ST_IDLE;
                r_shift   <= {IDLE_LVL, r_shift[FRAME_W-1:1]};
                r_bit_cnt <= '0;
            end else if (w_bit_tick) begin
                r_shift   <= {IDLE_LVL, r_shift[FRAME_W-1:1]};
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end
        end
    end

    assign ser_out    = out_en ? r_shift[0] : IDLE_LVL;
    assign busy       = w_busy;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_piso_frame_serializer.sv
// Bench for piso_frame_serializer: default instance plus a CLKS_PER_BIT=3, DATA_W=8 instance.
// Honours PISO_PARITY_EN when the build defines it.
module tb_piso_frame_serializer;

`ifdef PISO_PARITY_EN
    localparam int PW = 1;
`else
    localparam int PW = 0;
`endif
    localparam int FW  = 16 + PW;
    localparam int FW3 = 19 + PW;

    typedef struct {
        logic [4:0]    data;
        logic          oe;
        logic [FW-1:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic in_valid = 1'b0, in_ready, out_en = 1'b1, ser_out, busy, frame_done;
    logic [4:0] in_data = '0;
    logic in_valid3 = 1'b0, in_ready3, ser_out3, busy3, frame_done3;
    logic [7:0] in_data3 = '0;

    int n_checks = 0;
    int n_err    = 0;
    vec_t tbl [5];
    logic [FW3-1:0] exp3;

    always #5 clk = ~clk;

    piso_frame_serializer u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_en(out_en), .ser_out(ser_out), .busy(busy),
        .frame_done(frame_done)
    );

    piso_frame_serializer #(.DATA_W(8), .CLKS_PER_BIT(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid3), .in_ready(in_ready3),
        .in_data(in_data3), .out_en(1'b1), .ser_out(ser_out3), .busy(busy3),
        .frame_done(frame_done3)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic send_frame(input vec_t v);
        @(negedge clk);
        check("tbl_ready_idle", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_data  = v.data;
        out_en   = v.oe;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = ~v.data;
        for (int k = 0; k < FW; k++) begin
            @(negedge clk);
            check("tbl_ser", {31'd0, ser_out}, {31'd0, v.oe ? v.exp[k] : 1'b1});
            check("tbl_busy", {31'd0, busy}, 32'd1);
            check("tbl_ready", {31'd0, in_ready}, (k == FW - 1) ? 32'd1 : 32'd0);
            check("tbl_done_early", {31'd0, frame_done}, 32'd0);
        end
        @(negedge clk);
        check("tbl_done", {31'd0, frame_done}, 32'd1);
        check("tbl_busy_end", {31'd0, busy}, 32'd0);
        check("tbl_ser_idle", {31'd0, ser_out}, 32'd1);
        @(negedge clk);
        check("tbl_done_once", {31'd0, frame_done}, 32'd0);
        out_en = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
`ifdef PISO_PARITY_EN
        tbl[0] = '{5'b10110, 1'b1, {6'b111101, 1'b1, 5'b10110, 1'b0, 4'b1111}};
        tbl[1] = '{5'b00111, 1'b1, {6'b111101, 1'b1, 5'b00111, 1'b0, 4'b1111}};
        tbl[2] = '{5'b00011, 1'b1, {6'b111101, 1'b0, 5'b00011, 1'b0, 4'b1111}};
        tbl[3] = '{5'b11111, 1'b0, {6'b111101, 1'b1, 5'b11111, 1'b0, 4'b1111}};
        tbl[4] = '{5'b01001, 1'b1, {6'b111101, 1'b0, 5'b01001, 1'b0, 4'b1111}};
        exp3   = {6'b111101, 1'b0, 8'hA5, 1'b0, 4'b1111};
`else
        tbl[0] = '{5'b10110, 1'b1, 16'b1111_0110_1100_1111};
        tbl[1] = '{5'b00111, 1'b1, {6'b111101, 5'b00111, 1'b0, 4'b1111}};
        tbl[2] = '{5'b00011, 1'b1, {6'b111101, 5'b00011, 1'b0, 4'b1111}};
        tbl[3] = '{5'b11111, 1'b0, {6'b111101, 5'b11111, 1'b0, 4'b1111}};
        tbl[4] = '{5'b01001, 1'b1, {6'b111101, 5'b01001, 1'b0, 4'b1111}};
        exp3   = {6'b111101, 8'hA5, 1'b0, 4'b1111};
`endif

        // Reset state, both instances, with and without out_en.
        #1 rst_n = 1'b0;
        #1;
        check("rst_ready", {31'd0, in_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, frame_done}, 32'd0);
        check("rst_ser", {31'd0, ser_out}, 32'd1);
        check("rst_ready3", {31'd0, in_ready3}, 32'd1);
        check("rst_ser3", {31'd0, ser_out3}, 32'd1);
        out_en = 1'b0;
        #1;
        check("rst_ser_gated", {31'd0, ser_out}, 32'd1);
        out_en = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_ser", {31'd0, ser_out}, 32'd1);
        check("idle_busy", {31'd0, busy}, 32'd0);

        // Table-driven single frames.
        for (int i = 0; i < 5; i++) begin
            send_frame(tbl[i]);
        end

        // Back-to-back: in_valid held through three frames, data changed while not ready.
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = tbl[0].data;
        @(posedge clk);
        #1 in_data = tbl[1].data;
        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < FW; k++) begin
                @(negedge clk);
                check("b2b_ser", {31'd0, ser_out}, {31'd0, tbl[f].exp[k]});
                check("b2b_busy", {31'd0, busy}, 32'd1);
                check("b2b_ready", {31'd0, in_ready}, (k == FW - 1) ? 32'd1 : 32'd0);
                check("b2b_done", {31'd0, frame_done}, (f > 0 && k == 0) ? 32'd1 : 32'd0);
            end
            @(posedge clk);
            #1;
            if (f == 0) in_data = tbl[2].data;
            if (f == 1) in_valid = 1'b0;
        end
        @(negedge clk);
        check("b2b_done_last", {31'd0, frame_done}, 32'd1);
        check("b2b_idle", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check("b2b_done_clear", {31'd0, frame_done}, 32'd0);

        // Reset mid-frame while a zero bit is on the pin.
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 5'b10110;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (9) @(negedge clk);
        check("abort_pre_ser", {31'd0, ser_out}, 32'd0);
        #1 rst_n = 1'b0;
        #1;
        check("abort_ser", {31'd0, ser_out}, 32'd1);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("abort_no_done", {31'd0, frame_done}, 32'd0);
            check("abort_idle_ser", {31'd0, ser_out}, 32'd1);
        end
        send_frame(tbl[0]);

        // Slow instance: each bit held three clocks.
        @(negedge clk);
        in_valid3 = 1'b1;
        in_data3  = 8'hA5;
        @(posedge clk);
        #1;
        in_valid3 = 1'b0;
        in_data3  = 8'h00;
        for (int k = 0; k < FW3; k++) begin
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                check("slow_ser", {31'd0, ser_out3}, {31'd0, exp3[k]});
                check("slow_ready", {31'd0, in_ready3}, (k == FW3 - 1 && c == 2) ? 32'd1 : 32'd0);
                check("slow_done_early", {31'd0, frame_done3}, 32'd0);
            end
        end
        @(negedge clk);
        check("slow_done", {31'd0, frame_done3}, 32'd1);
        check("slow_busy_end", {31'd0, busy3}, 32'd0);
        @(negedge clk);
        check("slow_done_once", {31'd0, frame_done3}, 32'd0);
        check("slow_ser_idle", {31'd0, ser_out3}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
